serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B, LSB first, one bit per clock, Start/Busy/Done handshake.
// Optional signed-overflow flag built only when SERIAL_SUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bor_q, bor_d;
  logic               borrow_q, borrow_d;
  logic               accept_s, last_s, d_bit_s, bor_nxt_s;
  logic [WIDTH-1:0]   r_nxt_s;

  // Full-subtractor cell and handshake qualifiers
  always_comb begin
    d_bit_s   = a_q[0] ^ b_q[0] ^ bor_q;
    bor_nxt_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
    r_nxt_s   = {d_bit_s, r_q[WIDTH-1:1]};
    accept_s  = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_s    = (state_q == S_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_SHIFT;
        else       state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (last_s) state_d = S_DONE;
        else        state_d = S_SHIFT;
      end
      S_DONE: begin
        if (Start) state_d = S_SHIFT;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; results only move on the edge that enters DONE
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (accept_s) begin
      a_d   = A;
      b_d   = B;
      r_d   = '0;
      cnt_d = '0;
      bor_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      r_d   = r_nxt_s;
      cnt_d = cnt_q + CNT_W'(1);
      bor_d = bor_nxt_s;
      if (last_s) begin
        diff_d   = r_nxt_s;
        borrow_d = bor_nxt_s;
      end else begin
        diff_d   = diff_q;
        borrow_d = borrow_q;
      end
    end else begin
      a_d = a_q;
    end
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state_q)
      S_SHIFT: Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  assign Diff   = diff_q;
  assign Borrow = borrow_q;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic [1:0] msb_q, msb_d;
  logic       ovf_q, ovf_d;

  // Operand sign capture and overflow flag registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      msb_q <= 2'b00;
      ovf_q <= 1'b0;
    end else begin
      msb_q <= msb_d;
      ovf_q <= ovf_d;
    end
  end

  // Signed overflow: operand signs differ and result sign differs from minuend
  always_comb begin
    msb_d = msb_q;
    ovf_d = ovf_q;
    if (accept_s) begin
      msb_d = {A[WIDTH-1], B[WIDTH-1]};
    end else if (last_s) begin
      ovf_d = (msb_q[1] != msb_q[0]) && (r_nxt_s[WIDTH-1] != msb_q[1]);
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign Overflow = ovf_q;
`else
  assign Overflow = 1'b0;
`endif

endmodule
